bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Iterative binary-to-BCD converter using double dabble (add-3, then shift), one input bit per clock.
//   Parametrised in input width and digit count, with valid/ready handshakes on both sides.
//   Blanks leading zero digits with code 4'hF; the display decoder renders 4'hF as an unlit digit.
//   Sits between the ALU result register and the 7-segment display drivers.
// PARAMETERS
//   BIN_W     8   input width in bits, >= 2
//   DIGITS    3   BCD digits produced; out_bcd width is 4*DIGITS
//   BLANK_LZ  1   1 = replace leading zero digits with 4'hF; 0 = emit plain BCD
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          in_bin is valid
//   in_ready   out  1          converter can accept a value (state IDLE)
//   in_bin     in   BIN_W      unsigned binary operand (two's complement with BCD_SIGNED_EN)
//   out_valid  out  1          out_bcd, out_ovf and out_neg are valid
//   out_ready  in   1          consumer accepts the result
//   out_bcd    out  4*DIGITS   BCD result; digit 0 is in [3:0]
//   out_ovf    out  1          value exceeds 10^DIGITS-1; out_bcd holds the low DIGITS digits
//   out_neg    out  1          result is negative (BCD_SIGNED_EN only; otherwise tied 0)
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - state IDLE; shift and count registers cleared
//     - out_valid=0, out_bcd=0, out_ovf=0, out_neg=0; in_ready=1 once in IDLE
//     - reset mid-conversion abandons the operand; no partial result is ever presented
//   FSM states and transitions:
//     - IDLE: in_ready=1. in_valid&in_ready at an edge captures in_bin into the shift register,
//       clears the BCD accumulator and the overflow bit, loads count=BIN_W, moves to CONV.
//     - CONV: in_ready=0. Each cycle:
//         * every 4-bit digit >4 gets +3 (all digits in parallel)
//         * then {ovf_carry, bcd, shift} shifts left by 1; the MSB of shift enters digit 0
//         * a 1 shifted out of the top digit sets the sticky overflow bit
//         * count decrements; on the cycle count reaches 1, next state is DONE
//     - DONE: out_valid=1. Outputs stay stable until out_valid&out_ready, then IDLE.
//   Timing:
//     - latency: out_valid rises BIN_W+1 rising edges after the accepting edge
//     - throughput: one conversion per BIN_W+2 cycles; no overlap between conversions
//   Input/output rules:
//     - in_bin is sampled only at the accepting edge; later changes are ignored
//     - in_valid while busy is not accepted (in_ready=0); the producer holds it
//   Leading-zero blanking (BLANK_LZ=1):
//     - applied combinationally at the output stage
//     - scanning from the top digit down, each zero digit before the first nonzero one becomes 4'hF
//     - digit 0 is never blanked, so value 0 yields {F..F,0}
//     - with out_ovf=1, no blanking is applied
//   Arithmetic:
//     - +3 adjust is 4-bit; no digit exceeds 9 after the final shift when out_ovf=0
//     - no adjust is applied after the final shift
// CONFIGURATION
//   BCD_SIGNED_EN defined:
//     - in_bin is two's complement; the magnitude |in_bin| is formed at capture
//     - -2^(BIN_W-1) converts to magnitude 2^(BIN_W-1)
//     - out_neg = sign bit of the captured value, for nonzero values; latency unchanged
//   BCD_SIGNED_EN undefined:
//     - in_bin is unsigned; out_neg is constant 0
// TESTING
//   1. BIN_W=8, DIGITS=3, in_bin=255 -> out_bcd=12'h255, out_ovf=0, out_valid 9 edges after accept.
//   2. in_bin=81 -> 12'hF81; in_bin=0 -> 12'hFF0; BLANK_LZ=0, in_bin=7 -> 12'h007.
//   3. DIGITS=2, in_bin=200 -> out_ovf=1, out_bcd=8'h00; in_bin=99 -> 8'h99, out_ovf=0.
//   4. out_ready=0 for 5 cycles in DONE -> out_bcd stable, in_ready=0; accept 1 cycle after release.
//   5. rst_n low at CONV cycle 3 -> out_valid=0, in_ready=1; next in_bin=42 -> 12'hF42.
//   6. BCD_SIGNED_EN: in_bin=8'h80 -> out_neg=1, 12'h128; 8'hFF -> out_neg=1, 12'hFF1.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, valid/ready on both
// sides. Optional `BCD_SIGNED_EN treats in_bin as two's complement and converts its magnitude.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    in_bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_ovf,
    output logic                out_neg
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic [BIN_W-1:0]   w_mag;
    logic               w_neg_in;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_blank;
    logic               w_lead;

    assign w_accept = in_valid && (r_state == StIdle);

`ifdef BCD_SIGNED_EN
    // -2^(BIN_W-1) negates to itself, which read as unsigned is the correct magnitude.
    assign w_neg_in = in_bin[BIN_W-1];
    assign w_mag    = w_neg_in ? (~in_bin + BIN_W'(1)) : in_bin;
`else
    assign w_neg_in = 1'b0;
    assign w_mag    = in_bin;
`endif

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_bcd[4*i +: 4] > 4'd4) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= w_mag;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_neg   <= w_neg_in;
            r_cnt   <= CNT_W'(BIN_W);
        end else if (r_state == StConv) begin
            r_ovf   <= r_ovf | w_adj[BCD_W-1];
            r_bcd   <= {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
            r_shift <= {r_shift[BIN_W-2:0], 1'b0};
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (in_valid) w_state_d = StConv;
            StConv: if (r_cnt == CNT_W'(1)) w_state_d = StDone;
            StDone: if (out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Leading-zero blanking, top digit down; digit 0 always shown, none on overflow.
    always_comb begin
        w_blank = r_bcd;
        w_lead  = BLANK_LZ && !r_ovf;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (w_lead && (r_bcd[4*i +: 4] == 4'd0)) begin
                w_blank[4*i +: 4] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
        out_bcd   = out_valid ? w_blank : '0;
        out_ovf   = out_valid && r_ovf;
        out_neg   = out_valid && r_neg;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (3 digits blanked, 3 digits plain, 2 digits blanked)
// in lockstep, checked every cycle against a decimal-arithmetic model plus directed literals.
module tb_bin_to_bcd_seq;

    localparam int unsigned BIN_W = 8;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic in_bin_dummy;
    logic [BIN_W-1:0] in_bin;
    logic out_ready;

    logic        rdy_a, vld_a, ovf_a, neg_a;
    logic [11:0] bcd_a;
    logic        rdy_b, vld_b, ovf_b, neg_b;
    logic [11:0] bcd_b;
    logic        rdy_c, vld_c, ovf_c, neg_c;
    logic [7:0]  bcd_c;

    int vectors;
    int miscompares;

    // Timing model: 0 idle, 1..BIN_W converting, BIN_W+1 result presented.
    int               m_phase;
    logic [BIN_W-1:0] m_val;
    logic             m_done;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(3), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_bin(in_bin),
        .out_valid(vld_a), .out_ready(out_ready), .out_bcd(bcd_a), .out_ovf(ovf_a),
        .out_neg(neg_a)
    );
    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(3), .BLANK_LZ(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_bin(in_bin),
        .out_valid(vld_b), .out_ready(out_ready), .out_bcd(bcd_b), .out_ovf(ovf_b),
        .out_neg(neg_b)
    );
    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(2), .BLANK_LZ(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_bin(in_bin),
        .out_valid(vld_c), .out_ready(out_ready), .out_bcd(bcd_c), .out_ovf(ovf_c),
        .out_neg(neg_c)
    );

    always #5 clk = ~clk;

    function automatic int unsigned mag_of(input logic [BIN_W-1:0] v);
`ifdef BCD_SIGNED_EN
        return v[BIN_W-1] ? (2 ** BIN_W) - int'(v) : int'(v);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic neg_of(input logic [BIN_W-1:0] v);
`ifdef BCD_SIGNED_EN
        return v[BIN_W-1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] exp_bcd(input int unsigned mag, input int nd, input bit blank);
        int unsigned lim;
        int unsigned v;
        int unsigned d;
        bit          lead;
        logic [11:0] r;
        lim  = 10 ** nd;
        v    = mag % lim;
        lead = blank && (mag < lim);
        r    = '0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = (v / (10 ** i)) % 10;
            if (lead && d == 0 && i > 0) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                r[4*i +: 4] = d[3:0];
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1;
                m_val   <= in_bin;
            end
        end else if (m_phase <= int'(BIN_W)) begin
            m_phase <= m_phase + 1;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    assign m_done = (m_phase == int'(BIN_W) + 1);

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_a", rdy_a, m_phase == 0);
            chk("in_ready_b", rdy_b, m_phase == 0);
            chk("in_ready_c", rdy_c, m_phase == 0);
            chk("out_valid_a", vld_a, m_done);
            chk("out_valid_b", vld_b, m_done);
            chk("out_valid_c", vld_c, m_done);
            if (m_done) begin
                chk("bcd_a", bcd_a, exp_bcd(mag_of(m_val), 3, 1'b1));
                chk("bcd_b", bcd_b, exp_bcd(mag_of(m_val), 3, 1'b0));
                chk("bcd_c", bcd_c, exp_bcd(mag_of(m_val), 2, 1'b1));
                chk("ovf_a", ovf_a, mag_of(m_val) >= 1000);
                chk("ovf_b", ovf_b, mag_of(m_val) >= 1000);
                chk("ovf_c", ovf_c, mag_of(m_val) >= 100);
                chk("neg_a", neg_a, neg_of(m_val));
                chk("neg_b", neg_b, neg_of(m_val));
                chk("neg_c", neg_c, neg_of(m_val));
            end
        end
    end

    // Returns at the negedge following the accepting edge.
    task automatic send(input logic [BIN_W-1:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (m_phase != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_bin   = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_bin   = BIN_W'($urandom);
    endtask

    task automatic wait_done(input bit noisy, output int n);
        n = 0;
        while (!vld_a && n < 50) begin
            if (noisy) begin
                in_valid  = 1'($urandom);
                in_bin    = BIN_W'($urandom);
                out_ready = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!vld_a) begin
            miscompares++;
            $display("FAIL wait_done: out_valid never rose, got 0 expected 1");
        end
    endtask

    task automatic drain(input bit noisy);
        int n;
        n = 0;
        while (m_phase != 0 && n < 50) begin
            out_ready = noisy ? 1'($urandom) : 1'b1;
            @(negedge clk);
            n++;
        end
        out_ready = 1'b1;
        if (m_phase != 0) begin
            miscompares++;
            $display("FAIL drain: result not consumed, got busy expected idle");
        end
    endtask

    initial begin
        int n;
        clk          = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_bin       = '0;
        in_bin_dummy = 1'b0;
        out_ready    = 1'b1;
        vectors      = 0;
        miscompares  = 0;

        #12;
        chk("rst_in_ready", rdy_a, 1);
        chk("rst_out_valid", vld_a, 0);
        chk("rst_out_bcd", bcd_a, 12'h000);
        chk("rst_out_ovf", ovf_a, 0);
        chk("rst_out_neg", neg_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency counted including the accepting edge.
        send(8'd255);
        wait_done(1'b0, n);
        chk("latency_edges", n + 1, BIN_W + 1);
`ifndef BCD_SIGNED_EN
        chk("t255_bcd_a", bcd_a, 12'h255);
        chk("t255_ovf_a", ovf_a, 0);
        chk("t255_bcd_c", bcd_c, 8'h55);
        chk("t255_ovf_c", ovf_c, 1);
`endif
        drain(1'b0);

        send(8'd81);  wait_done(1'b0, n);
        chk("t81_bcd_a", bcd_a, 12'hF81);
        chk("t81_bcd_b", bcd_b, 12'h081);
        drain(1'b0);

        send(8'd0);   wait_done(1'b0, n);
        chk("t0_bcd_a", bcd_a, 12'hFF0);
        chk("t0_bcd_b", bcd_b, 12'h000);
        chk("t0_bcd_c", bcd_c, 8'hF0);
        drain(1'b0);

        send(8'd7);   wait_done(1'b0, n);
        chk("t7_bcd_b", bcd_b, 12'h007);
        chk("t7_bcd_a", bcd_a, 12'hFF7);
        drain(1'b0);

`ifndef BCD_SIGNED_EN
        send(8'd200); wait_done(1'b0, n);
        chk("t200_bcd_c", bcd_c, 8'h00);
        chk("t200_ovf_c", ovf_c, 1);
        chk("t200_bcd_a", bcd_a, 12'h200);
        drain(1'b0);
`endif

        send(8'd99);  wait_done(1'b0, n);
        chk("t99_bcd_c", bcd_c, 8'h99);
        chk("t99_ovf_c", ovf_c, 0);
        drain(1'b0);

        // Back-pressure: result held while out_ready is low.
        send(8'd123);
        out_ready = 1'b0;
        wait_done(1'b0, n);
        repeat (5) begin
            @(negedge clk);
            chk("hold_bcd_a", bcd_a, 12'h123);
            chk("hold_in_ready", rdy_a, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", rdy_a, 1);
        chk("release_out_valid", vld_a, 0);

        // Reset in the third conversion cycle.
        send(8'd99);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", vld_a, 0);
        chk("midrst_in_ready", rdy_a, 1);
        chk("midrst_out_bcd", bcd_a, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd42);  wait_done(1'b0, n);
        chk("t42_bcd_a", bcd_a, 12'hF42);
        drain(1'b0);

`ifdef BCD_SIGNED_EN
        send(8'h80);  wait_done(1'b0, n);
        chk("s80_bcd_a", bcd_a, 12'h128);
        chk("s80_neg_a", neg_a, 1);
        drain(1'b0);
        send(8'hFF);  wait_done(1'b0, n);
        chk("sff_bcd_a", bcd_a, 12'hFF1);
        chk("sff_neg_a", neg_a, 1);
        drain(1'b0);
`endif

        for (int k = 0; k < 300; k++) begin
            send(BIN_W'($urandom));
            wait_done(1'b1, n);
            drain(1'b1);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
